// File: rtl/poly_reduce_scheduler.sv
// Round-robin arbiter sharing one polynomial reduce engine among requesters.
// Fetches the source poly, runs the engine and streams 32 result words out.
module poly_reduce_scheduler #(
  parameter int NUM_REQ       = 3,
  parameter int O_BRAM_LENGTH = 96,
  parameter int WORDS         = 32,
  parameter int RAD_W         = 3,
  parameter int RD_LAT        = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*RAD_W-1:0]       req_rad,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             job_done,
  output logic                           busy,
  output logic [RAD_W-1:0]               src_rad,
  output logic                           eng_enable,
  input  logic                           eng_done,
  input  logic [WORDS*O_BRAM_LENGTH-1:0] eng_opoly,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [NUM_REQ-1:0]             wr_sel,
  output logic [$clog2(WORDS)-1:0]       wr_ad,
  output logic [O_BRAM_LENGTH-1:0]       wr_data
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(WORDS);
  localparam int FW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_WAIT, S_PUSH, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [RAD_W-1:0]   src_q, src_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [AW-1:0]      k_q, k_d;

  logic               found;
  logic [PW-1:0]      win_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      src_q   <= '0;
      fcnt_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      fcnt_q  <= fcnt_d;
      k_q     <= k_d;
    end
  end

  // First requester at or after ptr, wrapping around.
  always_comb begin : arb
    int j;
    j       = 0;
    found   = 1'b0;
    win_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win_sel = PW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    src_d   = src_q;
    fcnt_d  = fcnt_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d        = S_FETCH;
          win_d          = win_sel;
          gnt_d          = '0;
          gnt_d[win_sel] = 1'b1;
          src_d  = req_rad[int'(win_sel)*RAD_W +: RAD_W];
          fcnt_d = '0;
        end
      end
      S_FETCH: begin
        if (fcnt_q == FW'(RD_LAT - 1)) state_d = S_START;
        else fcnt_d = fcnt_q + 1'b1;
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          state_d = S_PUSH;
          k_d     = '0;
        end
      end
      S_PUSH: begin
        if (wr_ready) begin
          if (k_q == AW'(WORDS - 1)) state_d = S_DONE;
          else k_d = k_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    gnt        = gnt_q;
    src_rad    = src_q;
    busy       = (state_q != S_IDLE);
    eng_enable = (state_q == S_START);
    job_done   = (state_q == S_DONE) ? gnt_q : '0;
    wr_valid   = 1'b0;
    wr_sel     = '0;
    wr_ad      = '0;
    wr_data    = '0;
    if (state_q == S_PUSH) begin
      wr_valid = 1'b1;
      wr_sel   = gnt_q;
      wr_ad    = k_q;
      wr_data  = eng_opoly[int'(k_q)*O_BRAM_LENGTH +: O_BRAM_LENGTH];
    end
  end

endmodule

// File: tb/tb_poly_reduce_scheduler.sv
// Directed bench for poly_reduce_scheduler: arbitration order, push
// handshake with stalls, stray engine pulses, mid-job reset and req drop.
module tb_poly_reduce_scheduler;

  localparam int N  = 3;
  localparam int OW = 96;
  localparam int W  = 32;
  localparam int RW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*RW-1:0] req_rad = '0;
  logic [N-1:0]    gnt, job_done, wr_sel;
  logic            busy, eng_enable, wr_valid;
  logic [RW-1:0]   src_rad;
  logic            eng_done = 1'b0;
  logic [W*OW-1:0] eng_opoly = '0;
  logic            wr_ready = 1'b1;
  logic [4:0]      wr_ad;
  logic [OW-1:0]   wr_data;

  int n_run  = 0;
  int n_fail = 0;

  poly_reduce_scheduler #(
    .NUM_REQ(N), .O_BRAM_LENGTH(OW), .WORDS(W), .RAD_W(RW), .RD_LAT(1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_rad(req_rad), .gnt(gnt),
    .job_done(job_done), .busy(busy), .src_rad(src_rad),
    .eng_enable(eng_enable), .eng_done(eng_done), .eng_opoly(eng_opoly),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .wr_ad(wr_ad), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] coef(input int s, input int j);
    return 12'((s * 331 + j * 7 + (j >> 3) * 13) & 32'hfff);
  endfunction

  function automatic logic [W*OW-1:0] mk(input int s);
    logic [W*OW-1:0] v;
    v = '0;
    for (int j = 0; j < 256; j++) v[j*12 +: 12] = coef(s, j);
    return v;
  endfunction

  function automatic logic [OW-1:0] word(input int s, input int k);
    logic [OW-1:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c*12 +: 12] = coef(s, 8 * k + c);
    return v;
  endfunction

  // Called at a negedge while IDLE with req already set for winner w.
  task automatic job(input int w, input logic [2:0] rad, input int lat,
                     input bit stall, input bit stray, input bit dropw,
                     input bit hold, input int abort_at, input int seed);
    logic [N-1:0] g;
    int k, cyc;
    bit rdy;
    g = '0;
    g[w] = 1'b1;
    eng_opoly = mk(seed);
    @(negedge clk);
    check("gnt", gnt, g);
    check("src_rad", src_rad, rad);
    check("busy_job", busy, 1);
    check("en_fetch", eng_enable, 0);
    if (stray) eng_done = 1'b1;
    @(negedge clk);
    check("en_start", eng_enable, 1);
    check("wv_start", wr_valid, 0);
    @(negedge clk);
    eng_done = 1'b0;
    check("en_wait", eng_enable, 0);
    check("wv_wait0", wr_valid, 0);
    if (dropw) req[w] = 1'b0;
    repeat (lat - 1) begin
      @(negedge clk);
      check("wv_wait", wr_valid, 0);
    end
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    k = 0;
    cyc = 0;
    while (k < W && cyc < 200) begin
      check("wr_valid", wr_valid, 1);
      check("wr_ad", wr_ad, k);
      check("wr_data", wr_data, word(seed, k));
      check("wr_sel", wr_sel, g);
      check("jd_push", job_done, 0);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        check("rst_ctl", {gnt, job_done, busy, src_rad, eng_enable,
                          wr_valid, wr_sel, wr_ad}, 0);
        check("rst_data", wr_data, 0);
        req = '0;
        wr_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      rdy = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      wr_ready = rdy;
      if (rdy) k++;
      cyc++;
      @(negedge clk);
    end
    wr_ready = 1'b1;
    check("push_count", k, W);
    check("job_done", job_done, g);
    check("wv_done", wr_valid, 0);
    if (!hold) req[w] = 1'b0;
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("gnt_idle", gnt, 0);
    check("jd_idle", job_done, 0);
  endtask

  initial begin
    req_rad = {3'd6, 3'd5, 3'd2};
    #1 rst = 1'b1;
    #1;
    check("reset_ctl", {gnt, job_done, busy, src_rad, eng_enable,
                        wr_valid, wr_sel, wr_ad}, 0);
    check("reset_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // single request
    req = 3'b001;
    job(0, 3'd2, 2, 0, 0, 0, 0, -1, 1);

    // round robin from ptr 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 3'b111;
    job(0, 3'd2, 1, 0, 0, 0, 1, -1, 2);
    job(1, 3'd5, 3, 0, 0, 0, 1, -1, 3);
    job(2, 3'd6, 2, 0, 0, 0, 1, -1, 4);
    job(0, 3'd2, 1, 0, 0, 0, 1, -1, 5);
    req = '0;

    // write stalls
    req = 3'b010;
    job(1, 3'd5, 1, 1, 0, 0, 0, -1, 6);

    // stray eng_done in FETCH/START
    req = 3'b001;
    job(0, 3'd2, 3, 0, 1, 0, 0, -1, 7);

    // reset mid-push, then stale eng_done
    req = 3'b001;
    job(0, 3'd2, 1, 0, 0, 0, 0, 10, 8);
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    check("stale_wv", wr_valid, 0);
    check("stale_busy", busy, 0);
    @(negedge clk);
    check("stale_wv2", wr_valid, 0);
    req = 3'b100;
    job(2, 3'd6, 2, 0, 0, 0, 0, -1, 9);

    // requester drops req during WAIT
    req = 3'b010;
    job(1, 3'd5, 4, 0, 0, 1, 0, -1, 10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
